// File: rtl/casper_tx_pkt_arbiter_if.sv
// rtl/casper_tx_pkt_arbiter_if.sv - AXI-Stream bundle of N_LANES parallel lanes
interface casper_tx_pkt_arbiter_if #(
    parameter int N_LANES    = 1,
    parameter int DATA_WIDTH = 1024,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [N_LANES*DATA_WIDTH-1:0] tdata;
    logic [N_LANES*KEEP_WIDTH-1:0] tkeep;
    logic [N_LANES-1:0]            tvalid;
    logic [N_LANES-1:0]            tlast;
    logic [N_LANES-1:0]            tuser;
    logic [N_LANES-1:0]            tready;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/casper_tx_pkt_arbiter.sv
// rtl/casper_tx_pkt_arbiter.sv - packet-level round-robin arbiter for the 400G TX stream
module casper_tx_pkt_arbiter #(
    parameter int N_SRC         = 4,
    parameter int DATA_WIDTH    = 1024,
    parameter int KEEP_WIDTH    = 128,
    parameter int MAX_PKT_BEATS = 72,
    parameter int GAP_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    casper_tx_pkt_arbiter_if.slave  s,
    casper_tx_pkt_arbiter_if.master m,
    input  logic [N_SRC-1:0]        src_en,
    input  logic [GAP_W-1:0]        gap_cycles,
    output logic [2:0]              grant_id,
    output logic                    busy,
    output logic [31:0]             pkt_count,
    output logic [15:0]             trunc_count
);
    localparam int BEAT_W = $clog2(MAX_PKT_BEATS + 1);
    localparam logic [BEAT_W-1:0] LIMIT = BEAT_W'(MAX_PKT_BEATS - 1);

    typedef enum logic [1:0] {IDLE, SEND, FLUSH, GAP} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             rr_ptr;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [N_SRC-1:0]       req;
    logic                   arb_hit;
    logic [2:0]             arb_sel;
    int                     arb_idx;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [KEEP_WIDTH-1:0]  sel_keep;
    logic                   sel_valid, sel_last;
    logic                   at_limit, accept, leave_pkt;

    assign req      = s.tvalid & src_en;
    assign at_limit = (beat_cnt == LIMIT);
    assign busy     = (state == SEND) || (state == FLUSH);

    // First requester at or above rr_ptr, wrapping modulo N_SRC
    always_comb begin
        arb_hit = 1'b0;
        arb_sel = '0;
        arb_idx = 0;
        for (int i = 0; i < N_SRC; i++) begin
            arb_idx = (int'(rr_ptr) + i) % N_SRC;
            if (!arb_hit && req[arb_idx]) begin
                arb_hit = 1'b1;
                arb_sel = 3'(arb_idx);
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_id == 3'(i)) begin
                sel_data  = s.tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                sel_valid = s.tvalid[i];
                sel_last  = s.tlast[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        m.tdata   = sel_data;
        m.tkeep   = sel_keep;
        m.tvalid  = 1'b0;
        m.tlast   = 1'b0;
        m.tuser   = 1'b0;
        s.tready  = '0;
        accept    = 1'b0;
        leave_pkt = 1'b0;
        case (state)
            IDLE: if (arb_hit) state_nxt = SEND;
            SEND: begin
                m.tvalid = sel_valid;
                m.tlast  = sel_valid & (sel_last | at_limit);
                m.tuser  = sel_valid & at_limit & ~sel_last;
                s.tready = N_SRC'(m.tready) << grant_id;
                accept   = sel_valid & m.tready;
                if (accept && sel_last) begin
                    leave_pkt = 1'b1;
                    state_nxt = (gap_cycles != '0) ? GAP : IDLE;
                end else if (accept && at_limit) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Swallow the rest of an over-length packet without forwarding it
                s.tready = N_SRC'(1) << grant_id;
                if (sel_valid && sel_last) begin
                    leave_pkt = 1'b1;
                    state_nxt = (gap_cycles != '0) ? GAP : IDLE;
                end
            end
            GAP:     if (gap_cnt <= GAP_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            beat_cnt    <= '0;
            gap_cnt     <= '0;
            pkt_count   <= '0;
            trunc_count <= '0;
        end else begin
            if (state == IDLE && arb_hit) begin
                grant_id <= arb_sel;
                rr_ptr   <= (arb_sel == 3'(N_SRC - 1)) ? 3'd0 : arb_sel + 3'd1;
            end
            if (accept) beat_cnt <= (sel_last || at_limit) ? '0 : beat_cnt + 1'b1;
            if (leave_pkt)         gap_cnt <= gap_cycles;
            else if (state == GAP) gap_cnt <= gap_cnt - 1'b1;
            if (accept && (sel_last || at_limit)) pkt_count <= pkt_count + 32'd1;
            if (accept && at_limit && !sel_last && trunc_count != 16'hFFFF)
                trunc_count <= trunc_count + 16'd1;
        end
    end
endmodule
